uart_word_unpacker: RTL and testbench

Transmit-side counterpart of the receive word packer. Accepts a wide parallel word from the core and emits it as a sequence of OUTPUT_SIZE-bit chunks toward the UART transmitter, MSB chunk first. The first chunk out is the one the receive-side packer places in the MSB position, so a chunk stream looped back reassembles the original word. A one-word holding register lets the next word be loaded while the current one is shifting, so consecutive words produce chunks with no bubble.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_word_unpacker.sv | 137 +++++++++++++
 tb/tb_uart_word_unpacker.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART word/chunk definitions used by the transmit unpacker and the
// receive packer.
//   UART_WORD_W  : default parallel word width
//   UART_CHUNK_W : default serialised chunk width
//   state_t      : unpacker FSM state
package uart_pkg;

    localparam int unsigned UART_WORD_W  = 16;
    localparam int unsigned UART_CHUNK_W = 4;

    typedef enum logic [0:0] {
        EMPTY    = 1'b0,
        SHIFTING = 1'b1
    } state_t;

endpackage : uart_pkg

// File: rtl/uart_word_unpacker.sv
// Splits a parallel word from the core into OUTPUT_SIZE-bit chunks for the
// UART transmitter, MSB chunk first. A one-word holding register lets the
// next word be loaded while the current one shifts out, so consecutive words
// stream without a bubble.
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   data_in, in_valid : word from core; taken when in_valid && in_ready
//   in_ready          : a word can be accepted this cycle (registered)
//   data_out          : current chunk (top slice of the shifter)
//   out_valid         : data_out valid; consumed when out_valid && out_ready
//   out_ready         : transmitter consumes data_out this cycle
//   word_done         : one-cycle pulse after the last chunk of a word is consumed
//   busy              : shifter or holding register occupied
module uart_word_unpacker
    import uart_pkg::*;
#(
    parameter int unsigned INPUT_SIZE  = UART_WORD_W,
    parameter int unsigned OUTPUT_SIZE = UART_CHUNK_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INPUT_SIZE-1:0]  data_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [OUTPUT_SIZE-1:0] data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   word_done,
    output logic                   busy
);

    localparam int unsigned CHUNKS = INPUT_SIZE / OUTPUT_SIZE;
    localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

    // Reject geometries where the word does not split into whole chunks.
    if ((INPUT_SIZE % OUTPUT_SIZE) != 0 || CHUNKS < 1) begin : g_bad_cfg
        $error("uart_word_unpacker: INPUT_SIZE must be a non-zero multiple of OUTPUT_SIZE");
    end

    state_t                  state, state_n;
    logic [INPUT_SIZE-1:0]   sreg, sreg_n;
    logic [INPUT_SIZE-1:0]   hreg, hreg_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    hold_full, hold_full_n;
    logic                    in_ready_n, out_valid_n, word_done_n, busy_n;
    logic                    accept_c, consume_c, last_c;

    assign accept_c  = in_valid && in_ready;
    assign consume_c = out_valid && out_ready;
    assign last_c    = consume_c && (cnt == '0);

    // Chunk output is the top slice of the registered shifter.
    assign data_out = sreg[INPUT_SIZE-1 -: OUTPUT_SIZE];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            sreg      <= '0;
            hreg      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            word_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            hreg      <= hreg_n;
            cnt       <= cnt_n;
            hold_full <= hold_full_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            word_done <= word_done_n;
            busy      <= busy_n;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        hreg_n      = hreg;
        cnt_n       = cnt;
        hold_full_n = hold_full;
        word_done_n = 1'b0;

        unique case (state)
            EMPTY: begin
                if (accept_c) begin
                    sreg_n  = data_in;
                    cnt_n   = LAST_CNT;
                    state_n = SHIFTING;
                end
            end

            SHIFTING: begin
                if (consume_c && !last_c) begin
                    sreg_n = sreg << OUTPUT_SIZE;
                    cnt_n  = cnt - CNT_W'(1);
                end

                if (last_c) begin
                    word_done_n = 1'b1;
                    if (hold_full) begin
                        // Drain the hold register; a same-edge word refills it.
                        sreg_n      = hreg;
                        cnt_n       = LAST_CNT;
                        hold_full_n = 1'b0;
                        if (accept_c) begin
                            hreg_n      = data_in;
                            hold_full_n = 1'b1;
                        end
                    end else if (accept_c) begin
                        // Bypass the hold register when it is empty.
                        sreg_n = data_in;
                        cnt_n  = LAST_CNT;
                    end else begin
                        state_n = EMPTY;
                    end
                end else if (accept_c) begin
                    hreg_n      = data_in;
                    hold_full_n = 1'b1;
                end
            end

            default: state_n = EMPTY;
        endcase

        in_ready_n  = !hold_full_n;
        out_valid_n = (state_n == SHIFTING);
        busy_n      = (state_n == SHIFTING) || hold_full_n;
    end

endmodule : uart_word_unpacker

// File: tb/tb_uart_word_unpacker.sv
// Directed, table-driven bench for uart_word_unpacker (16-bit words, 4-bit chunks).
// Each vector drives inputs for one cycle and lists the outputs expected just
// after the following rising edge. A behavioural receive packer reassembles
// every consumed chunk stream for the loopback check.
module tb_uart_word_unpacker;

    localparam int unsigned IW = 16;
    localparam int unsigned OW = 4;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] data_in;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] data_out;
    logic          out_valid;
    logic          out_ready;
    logic          word_done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    uart_word_unpacker #(.INPUT_SIZE(IW), .OUTPUT_SIZE(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_done (word_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [IW-1:0] din;
        logic          ordy;
        logic          ov;
        logic [OW-1:0] dout;   // compared only when ov is expected high
        logic          ir;
        logic          wd;
        logic          bsy;
    } vec_t;

    vec_t vecs[$];
    int   n_main;

    // Receive-side packer model: shift consumed chunks in, MSB chunk first.
    logic [IW-1:0] acc;
    int            nib;
    logic [IW-1:0] words[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            nib <= 0;
        end else if (out_valid && out_ready) begin
            acc <= {acc[IW-OW-1:0], data_out};
            if (nib == 3) begin
                words.push_back({acc[IW-OW-1:0], data_out});
                nib <= 0;
            end else begin
                nib <= nib + 1;
            end
        end
    end

    function automatic void add(input logic iv, input logic [IW-1:0] din, input logic ordy,
                                input logic ov, input logic [OW-1:0] dout, input logic ir,
                                input logic wd, input logic bsy);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy;
        v.ov = ov; v.dout = dout; v.ir = ir; v.wd = wd; v.bsy = bsy;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        in_valid  = vecs[i].iv;
        data_in   = vecs[i].din;
        out_ready = vecs[i].ordy;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
        if (vecs[i].ov)
            chk($sformatf("v%0d_data_out", i), 32'(data_out), 32'(vecs[i].dout));
        chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
        chk($sformatf("v%0d_word_done", i), 32'(word_done), 32'(vecs[i].wd));
        chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
    endtask

    logic [IW-1:0] exp_words[10];

    initial begin
        //   iv  din       ordy  ov dout ir wd bsy
        // Single word, continuous drain
        add(1, 16'hA5C3, 1,   1, 4'hA, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h5, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'hC, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h3, 1, 0, 1);
        add(0, 16'h0000, 1,   0, 4'h0, 1, 1, 0);
        add(0, 16'h0000, 1,   0, 4'h0, 1, 0, 0);
        // Back-to-back words; second parks in the hold register
        add(1, 16'h1234, 1,   1, 4'h1, 1, 0, 1);
        add(1, 16'h5678, 1,   1, 4'h2, 0, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h3, 0, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h4, 0, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h5, 1, 1, 1);
        add(0, 16'h0000, 1,   1, 4'h6, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h7, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h8, 1, 0, 1);
        add(0, 16'h0000, 1,   0, 4'h0, 1, 1, 0);
        add(0, 16'h0000, 1,   0, 4'h0, 1, 0, 0);
        // Transmitter stall on the first chunk
        add(1, 16'h9ABC, 0,   1, 4'h9, 1, 0, 1);
        add(0, 16'h0000, 0,   1, 4'h9, 1, 0, 1);
        add(0, 16'h0000, 0,   1, 4'h9, 1, 0, 1);
        add(0, 16'h0000, 0,   1, 4'h9, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'hA, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'hB, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'hC, 1, 0, 1);
        add(0, 16'h0000, 1,   0, 4'h0, 1, 1, 0);
        add(0, 16'h0000, 1,   0, 4'h0, 1, 0, 0);
        // Hold register full, third word back-pressured
        add(1, 16'h1111, 0,   1, 4'h1, 1, 0, 1);
        add(1, 16'h2222, 0,   1, 4'h1, 0, 0, 1);
        add(1, 16'h3333, 0,   1, 4'h1, 0, 0, 1);
        add(1, 16'h3333, 1,   1, 4'h1, 0, 0, 1);
        add(1, 16'h3333, 1,   1, 4'h1, 0, 0, 1);
        add(1, 16'h3333, 1,   1, 4'h1, 0, 0, 1);
        add(1, 16'h3333, 1,   1, 4'h2, 1, 1, 1);
        add(1, 16'h3333, 1,   1, 4'h2, 0, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h2, 0, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h2, 0, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h3, 1, 1, 1);
        add(0, 16'h0000, 1,   1, 4'h3, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h3, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h3, 1, 0, 1);
        add(0, 16'h0000, 1,   0, 4'h0, 1, 1, 0);
        add(0, 16'h0000, 1,   0, 4'h0, 1, 0, 0);
        // New word accepted on the last-chunk edge with the hold register empty
        add(1, 16'h1234, 1,   1, 4'h1, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h2, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h3, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h4, 1, 0, 1);
        add(1, 16'h5678, 1,   1, 4'h5, 1, 1, 1);
        add(0, 16'h0000, 1,   1, 4'h6, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h7, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'h8, 1, 0, 1);
        add(0, 16'h0000, 1,   0, 4'h0, 1, 1, 0);
        add(0, 16'h0000, 1,   0, 4'h0, 1, 0, 0);
        n_main = vecs.size();
        // After the mid-word reset
        add(1, 16'hBEEF, 1,   1, 4'hB, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'hE, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'hE, 1, 0, 1);
        add(0, 16'h0000, 1,   1, 4'hF, 1, 0, 1);
        add(0, 16'h0000, 1,   0, 4'h0, 1, 1, 0);
        add(0, 16'h0000, 1,   0, 4'h0, 1, 0, 0);

        // Reset state
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        data_in   = 16'hFFFF;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_word_done", 32'(word_done), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        in_valid = 1'b0;
        data_in  = '0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < n_main; i++) run_vec(i);

        // Reset in the middle of 0xDEAD after two chunks were consumed
        in_valid = 1'b1; data_in = 16'hDEAD; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("mid_first_chunk", 32'(data_out), 32'hD);
        in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_second_chunk", 32'(data_out), 32'hE);
        @(posedge clk); #1;
        chk("mid_third_chunk", 32'(data_out), 32'hA);
        chk("mid_third_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_word_done", 32'(word_done), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_held_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rel_word_done", 32'(word_done), 32'd0);
        chk("mid_rel_out_valid", 32'(out_valid), 32'd0);

        for (int i = n_main; i < vecs.size(); i++) run_vec(i);

        // Loopback reassembly of every completed word
        exp_words[0] = 16'hA5C3; exp_words[1] = 16'h1234; exp_words[2] = 16'h5678;
        exp_words[3] = 16'h9ABC; exp_words[4] = 16'h1111; exp_words[5] = 16'h2222;
        exp_words[6] = 16'h3333; exp_words[7] = 16'h1234; exp_words[8] = 16'h5678;
        exp_words[9] = 16'hBEEF;
        chk("loop_word_count", 32'(words.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < words.size())
                chk($sformatf("loop_word%0d", i), 32'(words[i]), 32'(exp_words[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_word_unpacker
